// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector.
//
// Contents:
//   edge_mode_t  - run-time edge qualification mode, common to all channels
//   edge_qualify - combines rise/fall candidates with the mode bits
package edge_pkg;

    // Bit 0 enables rising edges, bit 1 enables falling edges.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    function automatic logic edge_qualify(input logic rise,
                                          input logic fall,
                                          input edge_mode_t mode);
        logic [1:0] m;
        m = mode;
        return (rise & m[0]) | (fall & m[1]);
    endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel of the edge detector: synchroniser chain, glitch filter,
// edge detection, sticky flag and saturating edge counter.
//
// Ports:
//   clk, n_rst    - clock, synchronous active-low reset
//   d_in          - asynchronous line input
//   edge_mode     - which edges are qualified (shared by all channels)
//   clear         - synchronous clear of sticky flag and counter
//   d_level       - filtered, synchronised line level
//   d_edge        - one-cycle pulse per qualified edge
//   edge_sticky   - set on a qualified edge, held until clear
//   edge_cnt      - saturating count of qualified edges
import edge_pkg::*;

module edge_filter_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic IDLE_VAL    = 1'b1,
    parameter int   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_in,
    input  edge_mode_t       edge_mode,
    input  logic             clear,
    output logic             d_level,
    output logic             d_edge,
    output logic             edge_sticky,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic             s;
    logic             rise;
    logic             fall;
    logic             qual;
    logic [CNT_W-1:0] cnt_base;

    assign s = sync_q[SYNC_STAGES-1];

    // Edge detection works purely on flops, so d_edge is glitch-free and
    // lasts exactly one cycle (filt_dly catches up on the next clock).
    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;
    assign qual = edge_qualify(rise, fall, edge_mode);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], d_in};
        filt_d     = filt_q;
        fcnt_d     = fcnt_q;
        filt_dly_d = filt_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        cnt_base   = cnt_q;

        // Glitch filter: a new level is accepted only after FILTER_LEN
        // consecutive differing samples; any matching sample restarts it.
        if (s == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCNT_LAST) begin
            filt_d = s;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end

        // Clear takes effect before a coincident edge is counted, so an
        // edge arriving with clear is never lost.
        if (clear) begin
            sticky_d = 1'b0;
            cnt_base = '0;
        end
        cnt_d = cnt_base;
        if (qual) begin
            sticky_d = 1'b1;
            if (cnt_base != {CNT_W{1'b1}}) begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q     <= {SYNC_STAGES{IDLE_VAL}};
            filt_q     <= IDLE_VAL;
            filt_dly_q <= IDLE_VAL;
            fcnt_q     <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            fcnt_q     <= fcnt_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign d_level     = filt_q;
    assign d_edge      = qual;
    assign edge_sticky = sticky_q;
    assign edge_cnt    = cnt_q;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector for the USB receive path and general line
// monitoring. Each channel is an independent edge_filter_ch instance.
//
// Ports:
//   clk, n_rst    - clock, synchronous active-low reset
//   d_in          - NUM_CH asynchronous line inputs
//   edge_mode     - NONE/RISE/FALL/BOTH, applied to all channels
//   clear         - synchronous clear of edge_sticky and edge_cnt
//   d_level       - filtered, synchronised line levels
//   d_edge        - one-cycle pulse per qualified edge
//   edge_sticky   - per-channel sticky edge flags
//   edge_cnt      - packed saturating counters, ch i at [i*CNT_W +: CNT_W]
import edge_pkg::*;

module edge_detect_mc #(
    parameter int   NUM_CH      = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic IDLE_VAL    = 1'b1,
    parameter int   CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       d_in,
    input  edge_mode_t              edge_mode,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       d_level,
    output logic [NUM_CH-1:0]       d_edge,
    output logic [NUM_CH-1:0]       edge_sticky,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] ch_cnt;

        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .IDLE_VAL    (IDLE_VAL),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk         (clk),
            .n_rst       (n_rst),
            .d_in        (d_in[i]),
            .edge_mode   (edge_mode),
            .clear       (clear),
            .d_level     (d_level[i]),
            .d_edge      (d_edge[i]),
            .edge_sticky (edge_sticky[i]),
            .edge_cnt    (ch_cnt)
        );

        assign edge_cnt[i*CNT_W +: CNT_W] = ch_cnt;
    end

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench for edge_detect_mc: a default-parameter instance and a
// CNT_W=2 instance share all inputs.
import edge_pkg::*;

module tb_edge_detect_mc;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] d_in;
    edge_mode_t edge_mode;
    logic       clear;

    logic [3:0]  d_level, d_edge, edge_sticky;
    logic [31:0] edge_cnt;
    logic [3:0]  d_level2, d_edge2, edge_sticky2;
    logic [7:0]  edge_cnt2;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    edge_detect_mc dut (
        .clk (clk), .n_rst (n_rst), .d_in (d_in), .edge_mode (edge_mode),
        .clear (clear), .d_level (d_level), .d_edge (d_edge),
        .edge_sticky (edge_sticky), .edge_cnt (edge_cnt)
    );

    edge_detect_mc #(.CNT_W(2)) dut2 (
        .clk (clk), .n_rst (n_rst), .d_in (d_in), .edge_mode (edge_mode),
        .clear (clear), .d_level (d_level2), .d_edge (d_edge2),
        .edge_sticky (edge_sticky2), .edge_cnt (edge_cnt2)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_pulses(input int ch, input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (d_edge[ch]) pulses++;
        end
    endtask

    // Returns the number of clocks until d_edge[ch] is seen, or -1 on timeout.
    task automatic wait_pulse(input int ch, input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            step(1);
            if (d_edge[ch]) begin
                cycles = k;
                break;
            end
        end
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return edge_cnt[ch*8 +: 8];
    endfunction

    function automatic logic [1:0] cnt2_of(input int ch);
        return edge_cnt2[ch*2 +: 2];
    endfunction

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        int p;
        int cyc;
        int any;

        // 1. reset release, lines idle
        n_rst = 1'b0; d_in = 4'hF; edge_mode = EDGE_BOTH; clear = 1'b0;
        step(2);
        check("rst_level", {28'd0, d_level}, 32'hF);
        check("rst_edge", {28'd0, d_edge}, 32'h0);
        n_rst = 1'b1;
        any = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (d_edge != 4'h0) any++;
        end
        check("idle_no_edge", any, 0);
        check("idle_level", {28'd0, d_level}, 32'hF);
        check("idle_cnt", edge_cnt, 32'h0);
        check("idle_sticky", {28'd0, edge_sticky}, 32'h0);

        // 2. ch0 falls: pulse visible 5 clocks after the change, one cycle wide
        d_in[0] = 1'b0;
        wait_pulse(0, 12, cyc);
        check("ch0_latency", cyc, 5);
        check("ch0_level_at_pulse", {31'd0, d_level[0]}, 32'h0);
        step(1);
        check("ch0_one_cycle", {31'd0, d_edge[0]}, 32'h0);
        check("ch0_cnt", cnt_of(0), 32'd1);
        check("ch0_sticky", {31'd0, edge_sticky[0]}, 32'h1);
        check("ch0_others_sticky", {29'd0, edge_sticky[3:1]}, 32'h0);

        // 3. ch1 glitches of 1 and 2 clocks are rejected, 3 clocks accepted
        d_in[1] = 1'b0; step(1); d_in[1] = 1'b1;
        count_pulses(1, 10, p);
        check("ch1_glitch1", p, 0);
        d_in[1] = 1'b0; step(2); d_in[1] = 1'b1;
        count_pulses(1, 10, p);
        check("ch1_glitch2", p, 0);
        check("ch1_level_kept", {31'd0, d_level[1]}, 32'h1);
        d_in[1] = 1'b0; step(3); d_in[1] = 1'b1;
        count_pulses(1, 20, p);
        check("ch1_pulse3_edges", p, 2);
        check("ch1_cnt", cnt_of(1), 32'd2);
        check("ch1_cnt_w2", cnt2_of(1), 32'd2);

        // 4. RISE only on ch2: 1->0 masked, 0->1 counted, 1->0 masked
        edge_mode = EDGE_RISE;
        d_in[2] = 1'b0; count_pulses(2, 10, p); any = p;
        d_in[2] = 1'b1; count_pulses(2, 10, p); any += p;
        d_in[2] = 1'b0; count_pulses(2, 10, p); any += p;
        check("ch2_rise_pulses", any, 1);
        check("ch2_rise_cnt", cnt_of(2), 32'd1);
        edge_mode = EDGE_NONE;
        d_in[2] = 1'b1; count_pulses(2, 10, p); any = p;
        d_in[2] = 1'b0; count_pulses(2, 10, p); any += p;
        check("ch2_none_pulses", any, 0);
        check("ch2_none_cnt", cnt_of(2), 32'd1);
        check("ch2_level", {31'd0, d_level[2]}, 32'h0);
        edge_mode = EDGE_BOTH;

        // 5. five edges on ch3: 8-bit counter reads 5, 2-bit counter saturates
        for (int k = 0; k < 5; k++) begin
            d_in[3] = ~d_in[3];
            step(8);
        end
        check("ch3_cnt5", cnt_of(3), 32'd5);
        check("ch3_sat", cnt2_of(3), 32'd3);
        // clear coincident with the pulse: edge counted after the clear
        d_in[3] = ~d_in[3];
        wait_pulse(3, 12, cyc);
        check("ch3_pulse_seen", cyc, 5);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_edge_cnt_w2", cnt2_of(3), 32'd1);
        check("clr_edge_cnt", cnt_of(3), 32'd1);
        check("clr_edge_sticky", {31'd0, edge_sticky2[3]}, 32'h1);
        check("clr_other_cnt", cnt_of(1), 32'd0);
        check("clr_other_sticky", {29'd0, edge_sticky[2:0]}, 32'h0);
        // clear alone
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_alone_cnt", edge_cnt, 32'h0);
        check("clr_alone_sticky", {28'd0, edge_sticky}, 32'h0);

        // 6a. reset while ch0/ch2 filters are part-way through a 0->1 change
        d_in = 4'hF;
        step(3);
        check("mid_filter_level", {28'd0, d_level}, 32'hA);
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        check("rst_mid_filter_level", {28'd0, d_level}, 32'hF);
        check("rst_mid_filter_edge", {28'd0, d_edge}, 32'h0);
        any = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (d_edge != 4'h0) any++;
        end
        check("after_rst_no_edge", any, 0);
        check("after_rst_cnt", edge_cnt, 32'h0);

        // 6b. reset while a pulse is on d_edge[1]
        d_in[1] = 1'b0;
        wait_pulse(1, 12, cyc);
        check("ch1_pulse_before_rst", cyc, 5);
        d_in[1] = 1'b1;
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        check("rst_mid_pulse_edge", {28'd0, d_edge}, 32'h0);
        check("rst_mid_pulse_cnt", cnt_of(1), 32'd0);
        check("rst_mid_pulse_sticky", {28'd0, edge_sticky}, 32'h0);
        count_pulses(1, 15, p);
        check("after_pulse_rst_quiet", p, 0);
        // a fresh full-length change is reported again
        d_in[1] = 1'b0;
        wait_pulse(1, 12, cyc);
        check("ch1_new_change", cyc, 5);
        step(1);
        check("ch1_new_cnt", cnt_of(1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
